// File: rtl/wdata_chan_arbiter_pkg.sv
// Shared definitions for the two-requester write-data channel arbiter:
// FSM state encoding, line geometry and the captured payload record.
package wdata_chan_arbiter_pkg;

    localparam int LINE_W = 128;
    localparam int MASK_W = 16;
    localparam int ID_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } state_e;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [LINE_W-1:0] wdata;
        logic [MASK_W-1:0] mask;
    } payload_t;

endpackage

// File: rtl/wdata_rr_pick.sv
// Combinational 2-way picker: round-robin on rr_ptr_i when both request
// (RR_EN=1), otherwise requester 0 has fixed priority.
module wdata_rr_pick #(
    parameter bit RR_EN = 1'b1
) (
    input  logic req0_i,
    input  logic req1_i,
    input  logic rr_ptr_i,
    output logic gnt_valid_o,
    output logic gnt_sel_o
);

    always_comb begin
        gnt_valid_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            gnt_sel_o = RR_EN ? rr_ptr_i : 1'b0;
        end else begin
            // A lone requester wins; with no request the value is unused.
            gnt_sel_o = ~req0_i;
        end
    end

endmodule

// File: rtl/wdata_chan_arbiter.sv
// Arbitrates two write-data requesters onto one write-data channel manager:
// capture, one-cycle start pulse, frozen payload until finish, sticky watchdog.
module wdata_chan_arbiter
    import wdata_chan_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1,
    parameter int TMO_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ID_W-1:0]   id0,
    input  logic [LINE_W-1:0] wdata0,
    input  logic [MASK_W-1:0] mask0,
    output logic              done0,
    input  logic              req1,
    input  logic [ID_W-1:0]   id1,
    input  logic [LINE_W-1:0] wdata1,
    input  logic [MASK_W-1:0] mask1,
    output logic              done1,
    output logic              next_rq,
    output logic [ID_W-1:0]   next_id,
    output logic [LINE_W-1:0] next_wdata,
    output logic [MASK_W-1:0] next_mask,
    input  logic              finish_wd,
    input  logic [ID_W-1:0]   finish_id,
    output logic              busy,
    output logic              tmo_err
);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              rr_ptr_q, rr_ptr_d;
    payload_t          hold_q, hold_d;
    logic [TMO_W-1:0]  wdog_q, wdog_d;
    logic              tmo_q, tmo_d;
    logic              next_rq_q, next_rq_d;
    logic              gnt_valid;
    logic              gnt_sel;

    wdata_rr_pick #(
        .RR_EN (RR_EN)
    ) u_pick (
        .req0_i      (req0),
        .req1_i      (req1),
        .rr_ptr_i    (rr_ptr_q),
        .gnt_valid_o (gnt_valid),
        .gnt_sel_o   (gnt_sel)
    );

    // State register.
    // NOTE: the holding registers drive module outputs directly, so they are
    // reset like control state rather than left as unreset datapath storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            rr_ptr_q  <= 1'b0;
            hold_q    <= '0;
            wdog_q    <= '0;
            tmo_q     <= 1'b0;
            next_rq_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            hold_q    <= hold_d;
            wdog_q    <= wdog_d;
            tmo_q     <= tmo_d;
            next_rq_q <= next_rq_d;
        end
    end

    // Next-state logic.
    // NOTE: every _d signal takes its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        hold_d   = hold_q;
        wdog_d   = wdog_q;
        tmo_d    = tmo_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    state_d = ST_ISSUE;
                    owner_d = gnt_sel;
                    if (gnt_sel) begin
                        hold_d.id    = id1;
                        hold_d.wdata = wdata1;
                        hold_d.mask  = mask1;
                    end else begin
                        hold_d.id    = id0;
                        hold_d.wdata = wdata0;
                        hold_d.mask  = mask0;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                wdog_d  = '0;
            end
            ST_WAIT: begin
                if (finish_wd) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = ~owner_q;
                    // A finish for a burst we did not issue is a protocol error.
                    if (finish_id != hold_q.id) begin
                        tmo_d = 1'b1;
                    end
                end else begin
                    if (!(&wdog_q)) begin
                        wdog_d = wdog_q + 1'b1;
                    end
                    if (&wdog_d) begin
                        tmo_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        next_rq_d = (state_d == ST_ISSUE);
    end

    // Output logic: done is combinational so it lands in the finish cycle.
    always_comb begin
        done0      = (state_q == ST_WAIT) && finish_wd && !owner_q;
        done1      = (state_q == ST_WAIT) && finish_wd &&  owner_q;
        busy       = (state_q != ST_IDLE);
        next_rq    = next_rq_q;
        next_id    = hold_q.id;
        next_wdata = hold_q.wdata;
        next_mask  = hold_q.mask;
        tmo_err    = tmo_q;
    end

endmodule

// File: tb/tb_wdata_chan_arbiter.sv
// Randomized bench for wdata_chan_arbiter: a round-robin instance (TMO_W=4) and
// a fixed-priority instance share stimulus; a transaction-level model predicts each grant.
module tb_wdata_chan_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0, req1;
    logic [3:0]   id0, id1;
    logic [127:0] wdata0, wdata1;
    logic [15:0]  mask0, mask1;
    logic         finish_wd;
    logic [3:0]   finish_id;

    logic         rr_done0, rr_done1, rr_next_rq, rr_busy, rr_tmo;
    logic [3:0]   rr_next_id;
    logic [127:0] rr_next_wdata;
    logic [15:0]  rr_next_mask;
    logic         fp_done0, fp_done1, fp_next_rq, fp_busy, fp_tmo;
    logic [3:0]   fp_next_id;
    logic [127:0] fp_next_wdata;
    logic [15:0]  fp_next_mask;

    logic         o_done0, o_done1, o_next_rq, o_busy, o_tmo;
    logic [3:0]   o_next_id;
    logic [127:0] o_next_wdata;
    logic [15:0]  o_next_mask;

    bit use_fp;
    int rr_ptr_m;
    bit exp_tmo;
    int n_checks;
    int n_fail;

    always #5 clk = ~clk;

    wdata_chan_arbiter #(.RR_EN(1'b1), .TMO_W(4)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .id0(id0), .wdata0(wdata0), .mask0(mask0), .done0(rr_done0),
        .req1(req1), .id1(id1), .wdata1(wdata1), .mask1(mask1), .done1(rr_done1),
        .next_rq(rr_next_rq), .next_id(rr_next_id), .next_wdata(rr_next_wdata),
        .next_mask(rr_next_mask), .finish_wd(finish_wd), .finish_id(finish_id),
        .busy(rr_busy), .tmo_err(rr_tmo)
    );

    wdata_chan_arbiter #(.RR_EN(1'b0), .TMO_W(8)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .id0(id0), .wdata0(wdata0), .mask0(mask0), .done0(fp_done0),
        .req1(req1), .id1(id1), .wdata1(wdata1), .mask1(mask1), .done1(fp_done1),
        .next_rq(fp_next_rq), .next_id(fp_next_id), .next_wdata(fp_next_wdata),
        .next_mask(fp_next_mask), .finish_wd(finish_wd), .finish_id(finish_id),
        .busy(fp_busy), .tmo_err(fp_tmo)
    );

    always_comb begin
        o_done0      = use_fp ? fp_done0      : rr_done0;
        o_done1      = use_fp ? fp_done1      : rr_done1;
        o_next_rq    = use_fp ? fp_next_rq    : rr_next_rq;
        o_busy       = use_fp ? fp_busy       : rr_busy;
        o_tmo        = use_fp ? fp_tmo        : rr_tmo;
        o_next_id    = use_fp ? fp_next_id    : rr_next_id;
        o_next_wdata = use_fp ? fp_next_wdata : rr_next_wdata;
        o_next_mask  = use_fp ? fp_next_mask  : rr_next_mask;
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic randomize_payload();
        id0    = 4'($urandom);
        id1    = 4'($urandom);
        wdata0 = rand128();
        wdata1 = rand128();
        mask0  = 16'($urandom);
        mask1  = 16'($urandom);
    endtask

    // Payload churn after capture, plus an optional early drop of the owner's req.
    task automatic scramble_inputs(input int win);
        randomize_payload();
        if ($urandom_range(1) == 1) begin
            if (win == 0) req0 = 1'b0;
            else          req1 = 1'b0;
        end
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req0      = 1'b0;
        req1      = 1'b0;
        finish_wd = 1'b0;
        finish_id = 4'h0;
        rr_ptr_m  = 0;
        exp_tmo   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Checks a quiet IDLE cycle with no requests pending.
    task automatic idle_check(input string tag);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0 || o_next_rq !== 1'b0 || o_done0 !== 1'b0 || o_done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: busy/next_rq/done0/done1 got %b%b%b%b required 0000",
                     tag, o_busy, o_next_rq, o_done0, o_done1);
        end
        n_checks++;
        if (o_tmo !== exp_tmo) begin
            n_fail++;
            $display("FAIL %s_idle_tmo: tmo_err got %b required %b", tag, o_tmo, exp_tmo);
        end
        @(posedge clk);
        #1;
    endtask

    // One grant from the IDLE cycle through the finish cycle. Starts just after
    // the edge that opens the IDLE cycle; ends just after the edge that opens the next one.
    task automatic run_burst(input int stall_pct, input int force_stall,
                             input bit scramble, input bit bad_id);
        int           win;
        int           beats;
        int           wait_cnt;
        int           cyc;
        int           tmo_lim;
        bit           fin;
        bit           rdy;
        logic [3:0]   e_id;
        logic [127:0] e_data;
        logic [15:0]  e_mask;

        tmo_lim = use_fp ? 255 : 15;
        if (req0 && req1) win = use_fp ? 0 : rr_ptr_m;
        else              win = req0 ? 0 : 1;
        e_id   = (win == 1) ? id1    : id0;
        e_data = (win == 1) ? wdata1 : wdata0;
        e_mask = (win == 1) ? mask1  : mask0;

        @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0 || o_next_rq !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_cycle: busy/next_rq got %b%b required 00", o_busy, o_next_rq);
        end
        n_checks++;
        if (o_tmo !== exp_tmo) begin
            n_fail++;
            $display("FAIL idle_tmo: tmo_err got %b required %b", o_tmo, exp_tmo);
        end
        @(posedge clk);
        #1;
        if (scramble) scramble_inputs(win);

        @(negedge clk);
        n_checks++;
        if (o_next_rq !== 1'b1 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_pulse: next_rq/busy got %b%b required 11", o_next_rq, o_busy);
        end
        n_checks++;
        if (o_next_id !== e_id || o_next_wdata !== e_data || o_next_mask !== e_mask) begin
            n_fail++;
            $display("FAIL issue_payload: got id=%h mask=%h data=%h required id=%h mask=%h data=%h",
                     o_next_id, o_next_mask, o_next_wdata, e_id, e_mask, e_data);
        end
        @(posedge clk);
        #1;

        beats    = 0;
        wait_cnt = 0;
        fin      = 1'b0;
        cyc      = 0;
        while (!fin && cyc < 200) begin
            rdy = (wait_cnt >= force_stall) &&
                  (($urandom_range(99) >= stall_pct) || (wait_cnt >= force_stall + 10));
            if (rdy) beats++;
            fin       = rdy && (beats == 4);
            finish_wd = fin;
            finish_id = bad_id ? ~e_id : e_id;
            if (scramble) scramble_inputs(win);
            @(negedge clk);
            n_checks++;
            if (o_next_rq !== 1'b0 || o_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL wait_ctrl: next_rq/busy got %b%b required 01", o_next_rq, o_busy);
            end
            n_checks++;
            if (o_next_id !== e_id || o_next_wdata !== e_data || o_next_mask !== e_mask) begin
                n_fail++;
                $display("FAIL wait_payload: got id=%h mask=%h data=%h required id=%h mask=%h data=%h",
                         o_next_id, o_next_mask, o_next_wdata, e_id, e_mask, e_data);
            end
            n_checks++;
            if (o_done0 !== (fin && win == 0) || o_done1 !== (fin && win == 1)) begin
                n_fail++;
                $display("FAIL done_pulse: done0/done1 got %b%b required %b%b",
                         o_done0, o_done1, fin && win == 0, fin && win == 1);
            end
            n_checks++;
            if (o_tmo !== exp_tmo) begin
                n_fail++;
                $display("FAIL wait_tmo: tmo_err got %b required %b (wait cycle %0d)",
                         o_tmo, exp_tmo, wait_cnt);
            end
            @(posedge clk);
            #1;
            finish_wd = 1'b0;
            if (fin) begin
                rr_ptr_m = 1 - win;
                if (bad_id) exp_tmo = 1'b1;
            end else begin
                wait_cnt++;
                if (wait_cnt >= tmo_lim) exp_tmo = 1'b1;
            end
            cyc++;
        end
        n_checks++;
        if (!fin) begin
            n_fail++;
            $display("FAIL burst_budget: burst got no finish after %0d cycles required completion", cyc);
        end
    endtask

    task automatic test_reset();
        use_fp = 1'b0;
        randomize_payload();
        rst_n = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        finish_wd = 1'b0;
        finish_id = 4'h0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({rr_next_rq, rr_done0, rr_done1, rr_busy, rr_tmo} !== 5'b0 ||
            {fp_next_rq, fp_done0, fp_done1, fp_busy, fp_tmo} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: rr=%b fp=%b required 00000",
                     {rr_next_rq, rr_done0, rr_done1, rr_busy, rr_tmo},
                     {fp_next_rq, fp_done0, fp_done1, fp_busy, fp_tmo});
        end
        n_checks++;
        if (rr_next_id !== 4'h0 || rr_next_wdata !== 128'h0 || rr_next_mask !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_payload: id=%h mask=%h data=%h required zeros",
                     rr_next_id, rr_next_mask, rr_next_wdata);
        end
        apply_reset();
        idle_check("reset");
    endtask

    task automatic test_single();
        use_fp = 1'b0;
        apply_reset();
        id0    = 4'h3;
        wdata0 = 128'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C;
        mask0  = 16'hFFFF;
        req0   = 1'b1;
        run_burst(0, 0, 1'b0, 1'b0);
        idle_check("single");
    endtask

    task automatic test_round_robin();
        use_fp = 1'b0;
        apply_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            randomize_payload();
            run_burst(0, 0, 1'b0, 1'b0);
        end
        idle_check("round_robin");
    endtask

    task automatic test_fixed_prio();
        use_fp = 1'b1;
        apply_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomize_payload();
            run_burst(25, 0, 1'b0, 1'b0);
        end
        req0 = 1'b0;
        randomize_payload();
        run_burst(25, 0, 1'b0, 1'b0);
        idle_check("fixed_prio");
    endtask

    task automatic test_random_stalls();
        int pat;
        use_fp = 1'b0;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            pat  = int'($urandom_range(1, 3));
            req0 = pat[0];
            req1 = pat[1];
            randomize_payload();
            run_burst(50, 0, 1'b1, 1'b0);
        end
        idle_check("random_stalls");
    endtask

    task automatic test_timeout();
        use_fp = 1'b0;
        randomize_payload();
        req0 = 1'b1;
        req1 = 1'b0;
        run_burst(0, 20, 1'b0, 1'b0);
        idle_check("timeout");
    endtask

    task automatic test_reset_mid_burst();
        use_fp = 1'b0;
        randomize_payload();
        req0 = 1'b1;
        req1 = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (o_busy !== 1'b1 || o_tmo !== exp_tmo) begin
            n_fail++;
            $display("FAIL midburst_pre: busy/tmo_err got %b%b required 1%b", o_busy, o_tmo, exp_tmo);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_next_rq, o_done0, o_done1, o_busy, o_tmo} !== 5'b0) begin
            n_fail++;
            $display("FAIL midburst_async_ctrl: got %b required 00000",
                     {o_next_rq, o_done0, o_done1, o_busy, o_tmo});
        end
        n_checks++;
        if (o_next_id !== 4'h0 || o_next_wdata !== 128'h0 || o_next_mask !== 16'h0) begin
            n_fail++;
            $display("FAIL midburst_async_payload: id=%h mask=%h data=%h required zeros",
                     o_next_id, o_next_mask, o_next_wdata);
        end
        rr_ptr_m = 0;
        exp_tmo  = 1'b0;
        req0 = 1'b0;
        req1 = 1'b1;
        randomize_payload();
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_burst(30, 0, 1'b0, 1'b0);
        idle_check("midburst");
    endtask

    task automatic test_id_mismatch();
        use_fp = 1'b1;
        apply_reset();
        randomize_payload();
        req1 = 1'b1;
        run_burst(0, 0, 1'b0, 1'b1);
        idle_check("id_mismatch");
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running at %0t required finish", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        use_fp   = 1'b0;
        rr_ptr_m = 0;
        exp_tmo  = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_fixed_prio();
        test_random_stalls();
        test_timeout();
        test_reset_mid_burst();
        test_id_mismatch();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
